// File: rtl/uart_cmd_assembler_if.sv
// rtl/uart_cmd_assembler_if.sv - byte-in / command-out handshake bundle for the UART command assembler
// The slave side is the assembler; the master side is the receiver plus command processor.
interface uart_cmd_assembler_if #(
  parameter int NUM_BYTES = 3
);
  logic                   rdy;
  logic [7:0]             rx_data;
  logic                   clr_rdy;
  logic [8*NUM_BYTES-1:0] cmd;
  logic                   cmd_rdy;
  logic                   clr_cmd_rdy;
  logic                   ovr_err;
  logic                   to_err;
  logic                   clr_err;

  modport slave (
    input  rdy, rx_data, clr_cmd_rdy, clr_err,
    output clr_rdy, cmd, cmd_rdy, ovr_err, to_err
  );

  modport master (
    output rdy, rx_data, clr_cmd_rdy, clr_err,
    input  clr_rdy, cmd, cmd_rdy, ovr_err, to_err
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - packs NUM_BYTES UART bytes (MSB first) into one command word
// Partial commands are dropped after TIMEOUT_CYC idle cycles; overrun and timeout are flagged sticky.
module uart_cmd_assembler #(
  parameter int NUM_BYTES   = 3,
  parameter int TIMEOUT_CYC = 2048
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_cmd_assembler_if.slave  bus
);
  localparam int              W       = 8 * NUM_BYTES;
  localparam logic [2:0]      NB      = 3'(NUM_BYTES);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {IDLE, COLLECT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   asm_q, asm_d;
  logic [W-1:0]   cmd_q, cmd_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [15:0]    timer_q, timer_d;
  logic           clr_rdy_q, clr_rdy_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic           ovr_q, ovr_d;
  logic           to_q, to_d;
  logic           accept;
  logic [W-1:0]   shifted;

  // rdy stays high one cycle into our clr_rdy pulse; the qualifier stops a second capture
  assign accept  = bus.rdy && !clr_rdy_q;
  assign shifted = (asm_q << 8) | W'(bus.rx_data);

  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    clr_rdy_d = accept;
    cmd_rdy_d = cmd_rdy_q && !bus.clr_cmd_rdy;
    ovr_d     = ovr_q && !bus.clr_err;
    to_d      = to_q && !bus.clr_err;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_rdy_q) begin
            ovr_d = 1'b1;
          end else begin
            asm_d   = W'(bus.rx_data);
            cnt_d   = 3'd1;
            timer_d = 16'd0;
            if (NB == 3'd1) begin
              cmd_d     = W'(bus.rx_data);
              cmd_rdy_d = 1'b1;
              cnt_d     = 3'd0;
            end else begin
              state_d = COLLECT;
            end
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          asm_d   = shifted;
          cnt_d   = cnt_q + 3'd1;
          timer_d = 16'd0;
          if (cnt_q + 3'd1 == NB) begin
            cmd_d     = shifted;
            cmd_rdy_d = 1'b1;
            cnt_d     = 3'd0;
            state_d   = IDLE;
            if (cmd_rdy_q) ovr_d = 1'b1;
          end
        end else if (timer_q == TO_LAST) begin
          asm_d   = '0;
          cnt_d   = 3'd0;
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      asm_q     <= '0;
      cmd_q     <= '0;
      cnt_q     <= 3'd0;
      timer_q   <= 16'd0;
      clr_rdy_q <= 1'b0;
      cmd_rdy_q <= 1'b0;
      ovr_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      clr_rdy_q <= clr_rdy_d;
      cmd_rdy_q <= cmd_rdy_d;
      ovr_q     <= ovr_d;
      to_q      <= to_d;
    end
  end

  assign bus.clr_rdy = clr_rdy_q;
  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.ovr_err = ovr_q;
  assign bus.to_err  = to_q;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - scoreboard bench for uart_cmd_assembler
// Stimulus pushes expected command words; a negedge monitor pops them as commands appear.
module tb_uart_cmd_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   clr_pulses = 0;
  logic [23:0] exp_q[$];
  logic        prev_rdy = 1'b0;
  logic [23:0] prev_cmd = '0;

  uart_cmd_assembler_if #(.NUM_BYTES(3)) bus ();

  uart_cmd_assembler #(.NUM_BYTES(3), .TIMEOUT_CYC(2048)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.clr_rdy) clr_pulses++;
    if (rst_n && bus.cmd_rdy && (!prev_rdy || bus.cmd != prev_cmd)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got 0x%0h expected none", bus.cmd);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (bus.cmd !== e) begin
          errors++;
          $display("FAIL cmd_word: got 0x%0h expected 0x%0h", bus.cmd, e);
        end
      end
    end
    prev_rdy = bus.cmd_rdy;
    prev_cmd = bus.cmd;
  end

  // Compliant receiver: rdy stays up through the edge that samples clr_rdy high
  task automatic send_byte(input logic [7:0] b, input bit ack_same, output logic cr_at_accept);
    bit seen;
    seen = 1'b0;
    cr_at_accept = 1'b0;
    bus.rx_data = b;
    bus.rdy = 1'b1;
    if (ack_same) bus.clr_cmd_rdy = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      bus.clr_cmd_rdy = 1'b0;
      if (bus.clr_rdy) begin
        seen = 1'b1;
        cr_at_accept = bus.cmd_rdy;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clr_rdy_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 bus.rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_cmd();
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_clr_err();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    logic cr;
    int   p0;
    bus.rdy = 1'b0;
    bus.rx_data = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    bus.clr_err = 1'b0;
    idle(3);
    check("reset_cmd", 32'(bus.cmd), 32'h0);
    check("reset_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    check("reset_clr_rdy", 32'(bus.clr_rdy), 32'h0);
    check("reset_errs", {30'h0, bus.ovr_err, bus.to_err}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    p0 = clr_pulses;
    exp_q.push_back(24'hA51234);
    send_byte(8'hA5, 1'b0, cr); idle(400);
    send_byte(8'h12, 1'b0, cr); idle(400);
    send_byte(8'h34, 1'b0, cr);
    check("latency_cmd_rdy", 32'(cr), 32'h1);
    idle(2);
    check("basic_pulses", 32'(clr_pulses - p0), 32'd3);
    check("basic_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("basic_errs", {30'h0, bus.ovr_err, bus.to_err}, 32'h0);
    ack_cmd();
    check("ack_clears", 32'(bus.cmd_rdy), 32'h0);
    check("ack_keeps_cmd", 32'(bus.cmd), 32'hA51234);

    // non-clearing receiver: rdy high for 5 edges gives accepts on edges 1, 3, 5
    p0 = clr_pulses;
    exp_q.push_back(24'h555555);
    @(negedge clk);
    bus.rx_data = 8'h55;
    bus.rdy = 1'b1;
    idle(5);
    bus.rdy = 1'b0;
    idle(3);
    check("stuck_rdy_pulses", 32'(clr_pulses - p0), 32'd3);
    ack_cmd();
    p0 = clr_pulses;
    exp_q.push_back(24'h112233);
    send_byte(8'h11, 1'b0, cr);
    send_byte(8'h22, 1'b0, cr);
    send_byte(8'h33, 1'b0, cr);
    idle(2);
    check("compliant_pulses", 32'(clr_pulses - p0), 32'd3);
    ack_cmd();

    send_byte(8'h01, 1'b0, cr);
    send_byte(8'h02, 1'b0, cr);
    idle(2046);
    check("to_err_before", 32'(bus.to_err), 32'h0);
    idle(2);
    check("to_err_after", 32'(bus.to_err), 32'h1);
    check("to_cmd_unchanged", 32'(bus.cmd), 32'h112233);
    exp_q.push_back(24'h102030);
    send_byte(8'h10, 1'b0, cr);
    send_byte(8'h20, 1'b0, cr);
    send_byte(8'h30, 1'b0, cr);
    idle(2);
    check("to_recover_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("to_err_sticky", 32'(bus.to_err), 32'h1);
    pulse_clr_err();
    check("to_err_cleared", 32'(bus.to_err), 32'h0);
    ack_cmd();

    exp_q.push_back(24'hAABBCC);
    send_byte(8'hAA, 1'b0, cr);
    send_byte(8'hBB, 1'b0, cr);
    send_byte(8'hCC, 1'b0, cr);
    p0 = clr_pulses;
    send_byte(8'h77, 1'b0, cr);
    idle(2);
    check("ovr_drained", 32'(clr_pulses - p0), 32'd1);
    check("ovr_err_set", 32'(bus.ovr_err), 32'h1);
    check("ovr_cmd_kept", 32'(bus.cmd), 32'hAABBCC);
    check("ovr_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    pulse_clr_err();
    check("ovr_err_cleared", 32'(bus.ovr_err), 32'h0);
    ack_cmd();

    exp_q.push_back(24'h0F0E0D);
    send_byte(8'h0F, 1'b0, cr);
    send_byte(8'h0E, 1'b0, cr);
    send_byte(8'h0D, 1'b1, cr);
    idle(2);
    check("set_wins_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("set_wins_cmd", 32'(bus.cmd), 32'h0F0E0D);
    ack_cmd();

    send_byte(8'h99, 1'b0, cr);
    send_byte(8'h98, 1'b0, cr);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_cmd", 32'(bus.cmd), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    exp_q.push_back(24'hC1C2C3);
    send_byte(8'hC1, 1'b0, cr);
    send_byte(8'hC2, 1'b0, cr);
    send_byte(8'hC3, 1'b0, cr);
    idle(2);
    check("post_rst_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("post_rst_errs", {30'h0, bus.ovr_err, bus.to_err}, 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
